// File: rtl/cpu_pkg.sv
// Shared PipelineCPU definitions: data-memory access types, XLEN and the MEM/WB record.
package cpu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        dm_word              = 3'b000,
        dm_halfword          = 3'b001,
        dm_halfword_unsigned = 3'b010,
        dm_byte              = 3'b011,
        dm_byte_unsigned     = 3'b100
    } dmtype_e;

    typedef struct packed {
        logic            valid;
        logic [4:0]      rd;
        logic            reg_write;
        logic [XLEN-1:0] data;
    } memwb_t;

    // Halfwords need an even address, words a 4-byte aligned one; bytes never fault.
    // Unknown encodings are treated like a word access.
    function automatic logic addr_misaligned(input logic [2:0] dmtype, input logic [1:0] offset);
        case (dmtype_e'(dmtype))
            dm_halfword, dm_halfword_unsigned: return offset[0];
            dm_byte, dm_byte_unsigned:         return 1'b0;
            default:                           return offset != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/halfword out of the raw memory word and sign/zero extends it.
module load_extend
    import cpu_pkg::*;
(
    input  logic [2:0]      dmtype,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] data_in,
    output logic [XLEN-1:0] data_out
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = data_in[8*gi +: 8];
    end

    assign byte_sel = lane[offset];
    assign half_sel = offset[1] ? data_in[31:16] : data_in[15:0];

    // Extension rule is chosen purely by access type; word (and unknown) passes the raw word.
    always_comb begin
        data_out = data_in;
        case (dmtype_e'(dmtype))
            dm_byte:              data_out = {{24{byte_sel[7]}}, byte_sel};
            dm_byte_unsigned:     data_out = {24'd0, byte_sel};
            dm_halfword:          data_out = {{16{half_sel[15]}}, half_sel};
            dm_halfword_unsigned: data_out = {16'd0, half_sel};
            default:              data_out = data_in;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: store lane alignment, data-memory port, stall request, forwarding source, MEM/WB register.
module mem_access_stage
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_rs2_data,
    input  logic [4:0]      ex_rd,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [2:0]      ex_dmtype,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] Data_in,
    input  logic            flush,
    output logic [XLEN-1:0] Addr_out,
    output logic [XLEN-1:0] Data_out,
    output logic [3:0]      be_out,
    output logic            mem_w,
    output logic [2:0]      DMType_out,
    output logic            stall_req,
    output logic            misalign,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic            wb_reg_write,
    output logic [XLEN-1:0] wb_data
);

    logic            active;
    logic            store_ok;
    logic            is_byte;
    logic            is_half;
    logic [1:0]      offset;
    logic [XLEN-1:0] store_lanes;
    logic [3:0]      lane_be;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] result;
    memwb_t          memwb_reg;
    memwb_t          memwb_next;

    assign offset   = ex_alu_result[1:0];
    assign active   = ex_valid & (ex_mem_read | ex_mem_write);
    assign misalign = active & addr_misaligned(ex_dmtype, offset);
    assign store_ok = active & ex_mem_write & ~misalign;
    assign is_byte  = (ex_dmtype == dm_byte) || (ex_dmtype == dm_byte_unsigned);
    assign is_half  = (ex_dmtype == dm_halfword) || (ex_dmtype == dm_halfword_unsigned);

    // Byte stores replicate into every lane, halfwords into both halves; the byte enables select.
    for (genvar gi = 0; gi < 4; gi++) begin : g_store_lane
        assign store_lanes[8*gi +: 8] = is_byte ? ex_rs2_data[7:0] :
                                        is_half ? ex_rs2_data[8*(gi%2) +: 8] :
                                                  ex_rs2_data[8*gi +: 8];
    end

    // Byte enables for the addressed lanes of a store.
    always_comb begin
        lane_be = 4'b1111;
        if (is_byte)      lane_be = 4'b0001 << offset;
        else if (is_half) lane_be = offset[1] ? 4'b1100 : 4'b0011;
    end

    assign Addr_out   = ex_valid ? {ex_alu_result[XLEN-1:2], 2'b00} : '0;
    assign Data_out   = (active & ex_mem_write) ? store_lanes : '0;
    assign be_out     = store_ok ? lane_be : 4'b0000;
    assign DMType_out = ex_valid ? ex_dmtype : 3'b000;
    assign mem_w      = store_ok & mem_ready & ~rst;
    assign stall_req  = active & ~misalign & ~mem_ready & ~rst;

    load_extend u_load_extend (
        .dmtype   (ex_dmtype),
        .offset   (offset),
        .data_in  (Data_in),
        .data_out (load_data)
    );

    assign result    = ex_mem_read ? load_data : ex_alu_result;
    assign fwd_valid = ex_valid & ex_reg_write & ~misalign & ~stall_req & (ex_rd != 5'd0);
    assign fwd_rd    = ex_valid ? ex_rd : 5'd0;
    assign fwd_data  = ex_valid ? result : '0;

    // MEM/WB next value: flush beats a stall, a stall inserts a bubble, otherwise capture.
    always_comb begin
        memwb_next = '0;
        if (!flush && !stall_req) begin
            memwb_next.valid     = ex_valid;
            memwb_next.rd        = ex_rd;
            memwb_next.reg_write = ex_reg_write & ~misalign;
            memwb_next.data      = result;
        end
    end

    // MEM/WB register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) memwb_reg <= '0;
        else     memwb_reg <= memwb_next;
    end

    assign wb_valid     = memwb_reg.valid;
    assign wb_rd        = memwb_reg.rd;
    assign wb_reg_write = memwb_reg.reg_write;
    assign wb_data      = memwb_reg.data;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised + directed bench for mem_access_stage against an arithmetic reference model.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_rs2_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_dmtype;
    logic        mem_ready;
    logic [31:0] Data_in;
    logic        flush;
    logic [31:0] Addr_out;
    logic [31:0] Data_out;
    logic [3:0]  be_out;
    logic        mem_w;
    logic [2:0]  DMType_out;
    logic        stall_req;
    logic        misalign;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
        .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_dmtype(ex_dmtype),
        .mem_ready(mem_ready), .Data_in(Data_in), .flush(flush),
        .Addr_out(Addr_out), .Data_out(Data_out), .be_out(be_out), .mem_w(mem_w),
        .DMType_out(DMType_out), .stall_req(stall_req), .misalign(misalign),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic bit m_misaligned(input logic [2:0] dm, input logic [31:0] addr);
        if (dm == 3'd1 || dm == 3'd2) return (addr % 2) != 0;
        if (dm == 3'd3 || dm == 3'd4) return 1'b0;
        return (addr % 4) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] dm, input logic [31:0] addr, input logic [31:0] din);
        logic [31:0] b, h;
        b = (din >> (8 * (addr % 4))) & 32'hFF;
        h = (din >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
        case (dm)
            3'd3:    return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
            3'd2:    return h;
            default: return din;
        endcase
    endfunction

    function automatic logic [31:0] m_store_data(input logic [2:0] dm, input logic [31:0] rs2);
        if (dm == 3'd3 || dm == 3'd4) return (rs2 & 32'hFF) * 32'h01010101;
        if (dm == 3'd1 || dm == 3'd2) return (rs2 & 32'hFFFF) * 32'h00010001;
        return rs2;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] dm, input logic [31:0] addr);
        if (dm == 3'd3 || dm == 3'd4) return 4'(1 << (addr % 4));
        if (dm == 3'd1 || dm == 3'd2) return 4'(3 << (2 * ((addr % 4) / 2)));
        return 4'hF;
    endfunction

    function automatic bit m_active();
        return ex_valid && (ex_mem_read || ex_mem_write);
    endfunction

    function automatic bit m_mis();
        return m_active() && m_misaligned(ex_dmtype, ex_alu_result);
    endfunction

    function automatic bit m_stall();
        return m_active() && !m_mis() && !mem_ready && !rst;
    endfunction

    function automatic logic [31:0] m_result();
        return ex_mem_read ? m_load(ex_dmtype, ex_alu_result, Data_in) : ex_alu_result;
    endfunction

    // Expected MEM/WB contents, advanced on each rising edge from the inputs present at that edge.
    bit          model_ok = 1'b0;
    logic        exp_valid, exp_rw;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;

    always @(posedge clk) begin
        if (rst) begin
            model_ok <= 1'b1;
            exp_valid <= 1'b0; exp_rw <= 1'b0; exp_rd <= 5'd0; exp_data <= 32'd0;
        end else if (flush || m_stall()) begin
            exp_valid <= 1'b0; exp_rw <= 1'b0;
        end else begin
            exp_valid <= ex_valid;
            exp_rw    <= ex_reg_write && !m_mis();
            exp_rd    <= ex_rd;
            exp_data  <= m_result();
        end
    end

    // Per-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (model_ok) begin
            bit fv;
            fv = ex_valid && ex_reg_write && !m_mis() && !m_stall() && (ex_rd != 5'd0);
            chk("stall_req", 32'(stall_req), 32'(m_stall()));
            chk("misalign", 32'(misalign), 32'(m_mis()));
            chk("mem_w", 32'(mem_w), 32'(m_active() && ex_mem_write && !m_mis() && mem_ready && !rst));
            chk("fwd_valid", 32'(fwd_valid), 32'(fv));
            chk("Addr_out", Addr_out, ex_valid ? (ex_alu_result & 32'hFFFFFFFC) : 32'd0);
            chk("DMType_out", 32'(DMType_out), ex_valid ? 32'(ex_dmtype) : 32'd0);
            if (m_active() && ex_mem_write && !m_mis()) begin
                chk("Data_out", Data_out, m_store_data(ex_dmtype, ex_rs2_data));
                chk("be_out", 32'(be_out), 32'(m_be(ex_dmtype, ex_alu_result)));
            end
            if (m_mis()) chk("be_out_mis", 32'(be_out), 32'd0);
            if (!ex_valid) begin
                chk("Data_out_idle", Data_out, 32'd0);
                chk("be_out_idle", 32'(be_out), 32'd0);
                chk("fwd_data_idle", fwd_data, 32'd0);
            end
            if (fv) begin
                chk("fwd_rd", 32'(fwd_rd), 32'(ex_rd));
                chk("fwd_data", fwd_data, m_result());
            end
            chk("wb_valid", 32'(wb_valid), 32'(exp_valid));
            chk("wb_reg_write", 32'(wb_reg_write), 32'(exp_rw));
            if (exp_valid) chk("wb_rd", 32'(wb_rd), 32'(exp_rd));
            if (exp_rw)    chk("wb_data", wb_data, exp_data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply(input bit r, input bit v, input logic [31:0] alu, input logic [31:0] rs2,
                         input logic [4:0] rd, input bit rw, input bit mr, input bit mw,
                         input logic [2:0] dm, input bit rdy, input logic [31:0] din, input bit fl);
        @(posedge clk);
        #1;
        rst = r; ex_valid = v; ex_alu_result = alu; ex_rs2_data = rs2; ex_rd = rd;
        ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_dmtype = dm;
        mem_ready = rdy; Data_in = din; flush = fl;
        $display("[TB] txn rst=%0b v=%0b addr=%08h rs2=%08h rd=%0d rw=%0b rd_op=%0b wr_op=%0b dm=%0d rdy=%0b din=%08h flush=%0b",
                 r, v, alu, rs2, rd, rw, mr, mw, dm, rdy, din, fl);
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 0, 0);
    endtask

    initial begin
        rst = 1; ex_valid = 0; ex_alu_result = 0; ex_rs2_data = 0; ex_rd = 0; ex_reg_write = 0;
        ex_mem_read = 0; ex_mem_write = 0; ex_dmtype = 0; mem_ready = 1; Data_in = 0; flush = 0;
        repeat (3) @(posedge clk);
        idle();
        // reset state
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        #2;
        chk("idle_Addr_out", Addr_out, 32'd0);
        chk("idle_fwd_valid", 32'(fwd_valid), 32'd0);

        // lw addr 0
        apply(0, 1, 32'h0, 0, 5'd15, 1, 1, 0, 3'd0, 1, 32'h87654321, 0);
        #2;
        chk("lw_fwd_data", fwd_data, 32'h87654321);
        chk("lw_fwd_valid", 32'(fwd_valid), 32'd1);
        // lb addr 3
        apply(0, 1, 32'h3, 0, 5'd1, 1, 1, 0, 3'd3, 1, 32'h80FF1234, 0);
        chk("lw_wb_data", wb_data, 32'h87654321);
        chk("lw_wb_rd", 32'(wb_rd), 32'd15);
        // lbu addr 3
        apply(0, 1, 32'h3, 0, 5'd2, 1, 1, 0, 3'd4, 1, 32'h80FF1234, 0);
        chk("lb_wb_data", wb_data, 32'hFFFFFF80);
        // lhu addr 2
        apply(0, 1, 32'h2, 0, 5'd3, 1, 1, 0, 3'd2, 1, 32'h80FF1234, 0);
        chk("lbu_wb_data", wb_data, 32'h00000080);
        // sb addr 1
        apply(0, 1, 32'h1, 32'h000000AB, 5'd0, 0, 0, 1, 3'd3, 1, 0, 0);
        chk("lhu_wb_data", wb_data, 32'h000080FF);
        #2;
        chk("sb_be", 32'(be_out), 32'b0010);
        chk("sb_data", Data_out, 32'hABABABAB);
        chk("sb_mem_w", 32'(mem_w), 32'd1);
        // sh addr 2
        apply(0, 1, 32'h2, 32'h00001234, 5'd0, 0, 0, 1, 3'd1, 1, 0, 0);
        #2;
        chk("sh_be", 32'(be_out), 32'b1100);
        chk("sh_data", Data_out, 32'h12341234);
        // sw addr 6 (misaligned)
        apply(0, 1, 32'h6, 32'hDEADBEEF, 5'd0, 0, 0, 1, 3'd0, 1, 0, 0);
        #2;
        chk("sw_mis", 32'(misalign), 32'd1);
        chk("sw_mis_mem_w", 32'(mem_w), 32'd0);
        chk("sw_mis_be", 32'(be_out), 32'd0);
        chk("sw_mis_stall", 32'(stall_req), 32'd0);
        // lh addr 1 (misaligned)
        apply(0, 1, 32'h1, 0, 5'd9, 1, 1, 0, 3'd1, 1, 32'h11223344, 0);
        #2;
        chk("lh_mis", 32'(misalign), 32'd1);
        idle();
        chk("lh_mis_wb_valid", 32'(wb_valid), 32'd1);
        chk("lh_mis_wb_reg_write", 32'(wb_reg_write), 32'd0);

        // lw stalled two cycles
        apply(0, 1, 32'h10, 0, 5'd7, 1, 1, 0, 3'd0, 0, 32'h0, 0);
        #2;
        chk("stall1", 32'(stall_req), 32'd1);
        apply(0, 1, 32'h10, 0, 5'd7, 1, 1, 0, 3'd0, 0, 32'h0, 0);
        chk("stall1_bubble", 32'(wb_valid), 32'd0);
        #2;
        chk("stall2", 32'(stall_req), 32'd1);
        apply(0, 1, 32'h10, 0, 5'd7, 1, 1, 0, 3'd0, 1, 32'h00005A5A, 0);
        chk("stall2_bubble", 32'(wb_valid), 32'd0);
        idle();
        chk("stall_retire_valid", 32'(wb_valid), 32'd1);
        chk("stall_retire_data", wb_data, 32'h00005A5A);
        chk("stall_retire_rd", 32'(wb_rd), 32'd7);

        // flushed addi
        apply(0, 1, 32'hF, 0, 5'd4, 1, 0, 0, 3'd0, 1, 0, 1);
        idle();
        chk("flush_wb_valid", 32'(wb_valid), 32'd0);
        chk("flush_wb_reg_write", 32'(wb_reg_write), 32'd0);

        // rst during a stall
        apply(0, 1, 32'hF, 0, 5'd4, 1, 0, 0, 3'd0, 1, 0, 0);
        apply(0, 1, 32'h20, 0, 5'd5, 1, 1, 0, 3'd0, 0, 0, 0);
        chk("pre_rst_wb_valid", 32'(wb_valid), 32'd1);
        apply(1, 1, 32'h20, 0, 5'd5, 1, 1, 0, 3'd0, 0, 0, 0);
        #2;
        chk("rst_stall_req", 32'(stall_req), 32'd0);
        idle();
        chk("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_mid_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_mid_wb_data", wb_data, 32'd0);

        // randomized phase, checked by the per-cycle compare process
        for (int i = 0; i < 400; i++) begin
            bit v, rw, mr, mw;
            int kind;
            v    = ($urandom_range(0, 9) != 0);
            kind = $urandom_range(0, 2);
            mr   = (kind == 0);
            mw   = (kind == 1);
            rw   = v && (kind != 1) && ($urandom_range(0, 7) != 0);
            apply(($urandom_range(0, 49) == 0), v, $urandom, $urandom, 5'($urandom_range(0, 31)),
                  rw, mr, mw, 3'($urandom_range(0, 4)), ($urandom_range(0, 3) != 0), $urandom,
                  ($urandom_range(0, 19) == 0));
        end
        idle();
        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the five-stage PipelineCPU, between the EX/MEM register and the writeback stage. It aligns store data onto byte lanes, drives the data-memory port and extracts and extends load data. It also owns the MEM/WB pipeline register and exports the current MEM-stage result to the forwarding unit, so a load's value reaches a dependent instruction one cycle after the load-use stall.

## Interface
- No parameters; widths fixed at RV32 (XLEN 32, 5-bit register index).
- clk  in  1  stage clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX/MEM holds a live instruction
- ex_alu_result  in  32  effective address, or ALU result for non-memory ops
- ex_rs2_data  in  32  store data, already forwarded
- ex_rd  in  5  destination register
- ex_reg_write  in  1  instruction writes rd
- ex_mem_read / ex_mem_write  in  1 each  load / store
- ex_dmtype  in  3  access type (see Structure)
- mem_ready  in  1  data memory completes the access this cycle
- Data_in  in  32  raw aligned word from data memory
- flush  in  1  kill the MEM/WB result (trap redirect)
- Addr_out  out  32  word address {addr[31:2],2'b00}
- Data_out  out  32  store data shifted onto byte lanes
- be_out  out  4  byte enables
- mem_w  out  1  write strobe
- DMType_out  out  3  ex_dmtype passthrough
- stall_req  out  1  memory not ready; hazard unit freezes PC/IF/ID/EX
- misalign  out  1  misaligned access detected this cycle
- fwd_valid, fwd_rd[4:0], fwd_data[31:0]  out  MEM-stage forwarding source
- wb_valid, wb_rd[4:0], wb_reg_write, wb_data[31:0]  out  MEM/WB register

## Operation
- Active access: ex_valid & (ex_mem_read | ex_mem_write).
- Misaligned: halfword types with addr[0]=1, or word with addr[1:0]!=0. misalign=1. mem_w=0 and be_out=0. The instruction retires to MEM/WB with wb_reg_write=0.
- Store lanes: byte = rs2[7:0] replicated 4×, be=1<<addr[1:0]. Half = rs2[15:0] replicated 2×, be=addr[1]?1100:0011. Word = rs2, be=1111.
- mem_w = active store & !misalign & mem_ready & !rst.
- Load extract: select the byte or halfword from Data_in by addr[1:0]. Sign-extend for dm_byte/dm_halfword, zero-extend for the _unsigned types; word passes through.
- Result mux: extracted load data if ex_mem_read, else ex_alu_result.
- stall_req = active access & !misalign & !mem_ready.
- MEM/WB update, in priority order:
  - rst: all wb_* = 0.
  - flush: wb_valid=0, wb_reg_write=0, others don't-care (cleared to 0).
  - stall_req: insert a bubble, wb_valid=0 and wb_reg_write=0.
  - otherwise: capture ex_valid, ex_rd, ex_reg_write & !misalign, and the result.
- Forwarding: fwd_valid = ex_valid & ex_reg_write & !misalign & !stall_req & (ex_rd!=0). fwd_rd=ex_rd, fwd_data=result mux. All three are combinational.
- Writes to x0: wb_reg_write may be 1, but the regfile ignores them. fwd_valid is never 1 for rd=0.

## Timing
- Memory read is combinational: Data_in is valid in the same cycle as Addr_out when mem_ready=1.
- Load latency: Addr_out in cycle N, wb_data in cycle N+1, fwd_data valid in cycle N.
- While stalled, EX/MEM is held upstream; outputs stay stable and mem_w stays 0 until mem_ready.
- flush together with stall_req: the flush wins and wb_valid=0. The stall is still requested.
- rst mid-stall: outputs reset next edge. stall_req is 0 while rst=1.
- Reset values: wb_* = 0. Combinational outputs read 0 with ex_valid=0.

## Structure
- Shared package cpu_pkg holds the dm_word=3'b000, dm_halfword=001, dm_halfword_unsigned=010, dm_byte=011 and dm_byte_unsigned=100 encodings and the XLEN constant.
- One sub-module, load_extend: combinational byte/half select plus sign/zero extension. The top holds the store alignment, stall logic and MEM/WB register.

## Test plan
- lw addr 0x0, Data_in=0x87654321, rd=15, mem_ready=1 -> fwd_data=0x87654321 same cycle; wb_data=0x87654321, wb_rd=15 next cycle.
- lb addr 0x3, Data_in=0x80FF1234 -> wb_data=0xFFFFFF80; lbu -> 0x00000080; lhu addr 0x2 -> 0x000080FF.
- sb rs2=0xAB addr 0x1 -> be_out=0010, Data_out=0xABABABAB, mem_w=1; sh addr 0x2 rs2=0x1234 -> be=1100, Data_out=0x12341234.
- sw addr 0x6 -> misalign=1, mem_w=0, be=0, stall_req=0; lh addr 0x1 -> misalign=1, wb_reg_write=0 next cycle.
- lw with mem_ready=0 for 2 cycles -> stall_req=1 for both, wb_valid=0 bubbles; 3rd cycle mem_ready=1 -> load retires.
- flush with a valid addi (rd=4, result 0xF) -> wb_valid=0; rst during a stall -> all wb_*=0 next edge.
